// File: rtl/sram_pkg.sv
// Shared types and constants for the half-word SRAM sequencer.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DATA_BASE_DEFAULT = 1024;
  localparam int SRAM_AW           = 18;

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit asynchronous SRAM
// accesses, each held on the pins for PHASE_CYCLES clocks.
//
// Handshake: a request (wr_en|rd_en) is accepted only in IDLE. ready is low
// from the request cycle until DONE, where it is high for exactly one cycle;
// the MEM stage must hold its request stable until it sees ready=1.
module sram_controller
  import sram_pkg::*;
#(
  parameter int          PHASE_CYCLES = 2,
  parameter logic [31:0] DATA_BASE    = DATA_BASE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [31:0]          address,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data,
  output logic                 ready,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [15:0]          sram_dq_out,
  input  logic [15:0]          sram_dq_in,
  output logic                 sram_dq_oe,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic                 sram_ub_n,
  output logic                 sram_lb_n,
  output logic [1:0]           dbg_state
);

  localparam logic [3:0] LAST = 4'(PHASE_CYCLES - 1);

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic [16:0] word_q;
  logic [15:0] data_hi_q;
  logic        req;
  logic        last;
  logic [18:0] offset_in;
  logic [16:0] word_in;
  logic        unused_bits;

  assign req  = wr_en | rd_en;
  assign last = (cnt == LAST);

  // Only the low 19 bits matter: the word index wraps modulo 2^17.
  assign offset_in   = address[18:0] - DATA_BASE[18:0];
  assign word_in     = offset_in[18:2];
  assign unused_bits = ^{address[31:19], offset_in[1:0]};

  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = ~req;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    case (state)
      IDLE: begin
        if (req) next_state = LO;
      end
      LO, HI: begin
        sram_ce_n = 1'b0;
        if (op_wr) begin
          sram_we_n  = 1'b0;
          sram_dq_oe = 1'b1;
        end else begin
          sram_oe_n = 1'b0;
        end
        if (last) next_state = (state == LO) ? HI : DONE;
      end
      DONE: begin
        ready      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Pin address/data are registered so they change only on phase boundaries
  // and hold their last value while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= 4'd0;
      op_wr       <= 1'b0;
      word_q      <= 17'd0;
      data_hi_q   <= 16'd0;
      read_data   <= 32'd0;
      sram_addr   <= '0;
      sram_dq_out <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_wr     <= wr_en;
            word_q    <= word_in;
            data_hi_q <= write_data[31:16];
            cnt       <= 4'd0;
            sram_addr <= {word_in, 1'b0};
            if (wr_en) sram_dq_out <= write_data[15:0];
          end
        end
        LO: begin
          if (last) begin
            cnt       <= 4'd0;
            sram_addr <= {word_q, 1'b1};
            if (op_wr) sram_dq_out <= data_hi_q;
            else       read_data[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HI: begin
          if (last) begin
            cnt <= 4'd0;
            if (!op_wr) read_data[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural SRAM and a
// reference word store feeding an expected-read queue.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;

  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [1:0]  dbg_state;

  logic [31:0] read_data1;
  logic        ready1;
  logic [17:0] sram_addr1;
  logic [15:0] sram_dq_out1;
  logic [15:0] sram_dq_in1 = 16'h0;
  logic        sram_dq_oe1, sram_ce_n1, sram_oe_n1, sram_we_n1, sram_ub_n1, sram_lb_n1;
  logic [1:0]  dbg_state1;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem[int];
  bit   [15:0] mem[0:262143];

  always #5 clk = ~clk;

  sram_controller #(.PHASE_CYCLES(2), .DATA_BASE(32'd1024)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
    .dbg_state(dbg_state)
  );

  sram_controller #(.PHASE_CYCLES(1), .DATA_BASE(32'd1024)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data1), .ready(ready1),
    .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_in(sram_dq_in1),
    .sram_dq_oe(sram_dq_oe1), .sram_ce_n(sram_ce_n1), .sram_oe_n(sram_oe_n1),
    .sram_we_n(sram_we_n1), .sram_ub_n(sram_ub_n1), .sram_lb_n(sram_lb_n1),
    .dbg_state(dbg_state1)
  );

  // Behavioural SRAM for the P=2 instance.
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_dq_out;
  end
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One full P=2 access starting at the next clock; lo_addr is the expected
  // SRAM address of the low half-word. hold keeps the request asserted.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [17:0] lo_addr,
                        input bit hold);
    int key;
    logic [31:0] exp_v;
    key = int'(lo_addr >> 1);
    tick();
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    if (wr) ref_mem[key] = d;
    else    exp_q.push_back(ref_mem.exists(key) ? ref_mem[key] : 32'h0);
    @(negedge clk);
    chk("req_ready", {31'd0, ready}, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (!hold) begin
        wr_en = 1'b0; rd_en = 1'b0; address = $urandom; write_data = $urandom;
      end
      @(negedge clk);
      chk("sram_addr", {14'd0, sram_addr}, {14'd0, (c <= 2) ? lo_addr : (lo_addr | 18'd1)});
      chk("ce_n", {31'd0, sram_ce_n}, 32'd0);
      chk("phase_ready", {31'd0, ready}, {31'd0, ~(wr_en | rd_en)});
      if (wr) begin
        chk("we_n_wr", {31'd0, sram_we_n}, 32'd0);
        chk("oe_n_wr", {31'd0, sram_oe_n}, 32'd1);
        chk("dq_oe_wr", {31'd0, sram_dq_oe}, 32'd1);
        chk("dq_out", {16'd0, sram_dq_out}, {16'd0, (c <= 2) ? d[15:0] : d[31:16]});
      end else begin
        chk("we_n_rd", {31'd0, sram_we_n}, 32'd1);
        chk("oe_n_rd", {31'd0, sram_oe_n}, 32'd0);
        chk("dq_oe_rd", {31'd0, sram_dq_oe}, 32'd0);
      end
    end
    tick();
    @(negedge clk);
    chk("done_ready", {31'd0, ready}, 32'd1);
    chk("done_ce_n", {31'd0, sram_ce_n}, 32'd1);
    chk("done_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("done_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    if (!wr) begin
      exp_v = exp_q.pop_front();
      chk("read_data", read_data, exp_v);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_ctl_n", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
    chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("byte_en", {30'd0, sram_ub_n, sram_lb_n}, 32'd0);
    rst = 1'b0;

    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'd0, 1'b0);
    access(1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 1'b0);
    access(1'b1, 1'b0, 32'd1036, $urandom, 18'd6, 1'b0);
    access(1'b0, 1'b1, 32'd1036, 32'h0, 18'd6, 1'b0);
    access(1'b1, 1'b0, 32'd1020, $urandom, 18'h3FFFE, 1'b0);
    access(1'b0, 1'b1, 32'd1020, 32'h0, 18'h3FFFE, 1'b0);

    // Back-to-back loads with the request held through DONE.
    access(1'b0, 1'b1, 32'd1036, 32'h0, 18'd6, 1'b1);
    access(1'b0, 1'b1, 32'd1020, 32'h0, 18'h3FFFE, 1'b1);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;

    // Both enables set: the write wins, then read it back.
    access(1'b1, 1'b1, 32'd1040, $urandom, 18'd8, 1'b0);
    access(1'b0, 1'b1, 32'd1040, 32'h0, 18'd8, 1'b0);

    // Reset asserted during the HI phase of a write.
    tick();
    wr_en = 1'b1; address = 32'd1100; write_data = 32'hCAFEF00D;
    tick();
    wr_en = 1'b0;
    tick();
    tick();
    chk("pre_rst_we_n", {31'd0, sram_we_n}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("mid_rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("mid_rst_read_data", read_data, 32'd0);
    chk("mid_rst_sram_addr", {14'd0, sram_addr}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready}, 32'd1);
    chk("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle phases on the P=1 instance.
    tick();
    wr_en = 1'b1; address = 32'd1032; write_data = 32'h12345678;
    @(negedge clk);
    chk("p1_req_ready", {31'd0, ready1}, 32'd0);
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("p1_lo_addr", {14'd0, sram_addr1}, 32'd4);
    chk("p1_lo_dq", {16'd0, sram_dq_out1}, 32'h5678);
    chk("p1_lo_we_n", {31'd0, sram_we_n1}, 32'd0);
    chk("p1_lo_ready", {31'd0, ready1}, 32'd1);
    tick();
    @(negedge clk);
    chk("p1_hi_addr", {14'd0, sram_addr1}, 32'd5);
    chk("p1_hi_dq", {16'd0, sram_dq_out1}, 32'h1234);
    chk("p1_hi_dq_oe", {31'd0, sram_dq_oe1}, 32'd1);
    tick();
    @(negedge clk);
    chk("p1_done_ready", {31'd0, ready1}, 32'd1);
    chk("p1_done_we_n", {31'd0, sram_we_n1}, 32'd1);
    chk("p1_done_state", {30'd0, dbg_state1}, 32'd3);
    tick();
    @(negedge clk);
    chk("p1_idle_state", {30'd0, dbg_state1}, 32'd0);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Sequences the external 16-bit asynchronous SRAM on behalf of the MEM stage, replacing the single-cycle data memory. Each 32-bit load/store is split into two half-word SRAM accesses timed by a phase counter. `ready` drops combinationally on the request cycle, and the top level ORs `~ready` into the pipeline freeze until the access completes.

## Interface
- `PHASE_CYCLES`, default 2, clocks each half-word phase is held on the SRAM pins (legal 1..15).
- `DATA_BASE`, default 1024, byte address mapped to SRAM word 0.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: store request from the MEM stage (EXE-reg `mem_write`).
- `rd_en` in 1: load request from the MEM stage (EXE-reg `mem_read`).
- `address` in 32: byte address (EXE-reg ALU result).
- `write_data` in 32: store data (EXE-reg `val_rm`).
- `read_data` out 32: load result, held until the next load completes.
- `ready` out 1: 0 while a request is outstanding; the pipeline freezes on 0.
- `sram_addr` out 18: SRAM half-word address.
- `sram_dq_out` out 16: write data to the pad.
- `sram_dq_in` in 16: read data from the pad.
- `sram_dq_oe` out 1: pad output enable, 1 only during write phases.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` out 1 each: active-low chip, output and write enables.
- `sram_ub_n`, `sram_lb_n` out 1 each: byte enables, tied 0.

## Operation
- FSM states: IDLE, LO, HI, DONE. Phase counter is 4 bits.
- **IDLE:**
  - If `wr_en|rd_en`, latch the op (`wr_en` has priority if both are set), `address` and `write_data`.
  - Clear the counter and go to LO.
  - Otherwise stay in IDLE.
- **LO:** drive the low half-word.
  - Count 0..PHASE_CYCLES-1. At the last count go to HI and clear the counter.
- **HI:** drive the high half-word with the same counting.
  - At the last count go to DONE.
- **DONE:** one cycle, then IDLE unconditionally.
- `ready` = 1 in DONE. In all other states `ready` = ~(`wr_en`|`rd_en`), i.e. 0 on the IDLE request cycle.
- Address map:
  - word = (latched address − DATA_BASE)[18:2], truncated.
  - `sram_addr` = {word, 0} in LO and {word, 1} in HI.
  - Out-of-range addresses wrap modulo 2^17 words. Bits [1:0] are ignored.
- **Write phases:**
  - `sram_ce_n`=0, `sram_we_n`=0, `sram_oe_n`=1, `sram_dq_oe`=1.
  - `sram_dq_out` = data[15:0] in LO and data[31:16] in HI.
- **Read phases:**
  - `sram_ce_n`=0, `sram_oe_n`=0, `sram_we_n`=1, `sram_dq_oe`=0.
  - On the last LO count, register `sram_dq_in` into `read_data[15:0]`. On the last HI count, register it into `read_data[31:16]`.
- In IDLE and DONE: `sram_ce_n`=`sram_oe_n`=`sram_we_n`=1, `sram_dq_oe`=0. `sram_addr` and `sram_dq_out` hold their last values.
- Inputs are ignored outside IDLE. Deasserting a request mid-access does not abort it.

## Timing
- The request is seen in IDLE at cycle 0. LO spans cycles 1..P and HI spans P+1..2P. DONE (`ready`=1) is cycle 2P+1, and the pipeline advances at the end of that cycle.
- Default P=2: 6 cycles per access, 5 freeze cycles.
- `read_data` is valid from DONE onward. Its upper half changes at the clock edge entering DONE.
- Back-to-back requests: the cycle after DONE is IDLE and accepts a new request immediately, with `ready`=0 again on that cycle. There is no bubble beyond DONE.
- Moore outputs: all SRAM pins decode registered state and latched data only. `ready` is the only combinational path (request → `ready`).
- Reset, including mid-access:
  - State IDLE, counter 0.
  - `read_data`=0, latched op/address/data = 0, `sram_addr`=0, `sram_dq_out`=0.
  - All active-low controls = 1, `sram_dq_oe`=0, `ready`=1 when no request is present.

## Structure
- Package `sram_pkg`: the state enum (IDLE, LO, HI, DONE), `DATA_BASE_DEFAULT`=1024, and `SRAM_AW`=18.
- A single module with no sub-module. The counter and FSM are inline.
- The top level gates all pipeline register enables and the PC with `freeze | ~ready`.

## Test plan
- **Store then load, P=2:**
  - Stimulus: `wr_en`, `address`=1024, `write_data`=0xDEADBEEF.
  - Required: `sram_addr` is 0 in cycles 1–2 with `dq_out`=0xBEEF, then 1 in cycles 3–4 with 0xDEAD, and `ready`=1 at cycle 5.
  - Follow-up: a load from the same address returns 0xDEADBEEF at its DONE cycle.
- **Address map:** load from 1036 → `sram_addr` 6 then 7. Load from 1020 → word 0x1FFFF, `sram_addr` 0x3FFFE then 0x3FFFF.
- **Back-to-back:** two loads with the request held asserted → `ready` pattern 0,0,0,0,0,1,0,0,0,0,0,1. The second access starts the cycle after DONE.
- **Conflict and ignore:**
  - `rd_en`=`wr_en`=1 → a write is performed.
  - Changing `address` during LO does not change `sram_addr`.
- **Reset mid-access:** assert `rst` in HI of a write → the same cycle shows `sram_we_n`=1, `dq_oe`=0, `read_data`=0. With no request after reset, `ready`=1.
- **P=1:** a store takes 4 cycles (`ready`=1 at cycle 3), and each phase is exactly 1 cycle with the correct half-word.
